// File: rtl/cache_mem_arbiter_pkg.sv
// cache_types: state, owner and captured memory-request types shared by the
// instruction/data cache memory-port arbiter.
package cache_types;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_LINE_W = 256;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} arb_state_t;
    typedef enum logic {ICACHE, DCACHE} arb_owner_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  read;
        logic                  write;
        logic [REQ_LINE_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/cache_mem_arbiter_req_reg.sv
// arb_req_reg: holds the granted memory request stable until the next grant.
module arb_req_reg import cache_types::*; (
    input  logic     clk,
    input  logic     clr_i,
    input  logic     ld_i,
    input  mem_req_t req_i,
    output mem_req_t req_o
);
    mem_req_t req_q;

    always_ff @(posedge clk) begin
        if (clr_i) req_q <= '0;
        else if (ld_i) req_q <= req_i;
    end

    assign req_o = req_q;
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one cacheline memory port between the
// icache and dcache, keeping a dcache write-back and its refill back-to-back.
module cache_mem_arbiter import cache_types::*; #(
    parameter int ADDR_W      = REQ_ADDR_W,
    parameter int LINE_W      = REQ_LINE_W,
    parameter bit REFILL_LOCK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    arb_state_t state_q, state_d;
    arb_owner_t last_grant_q, last_grant_d;
    mem_req_t   req_d, req_q;
    logic       req_ld, d_req, gnt_i, gnt_d, refill, busy, spurious;

    arb_req_reg u_req (
        .clk   (clk),
        .clr_i (rst),
        .ld_i  (req_ld),
        .req_i (req_d),
        .req_o (req_q)
    );

    assign d_req  = d_read || d_write;
    assign gnt_i  = i_read && (!d_req || last_grant_q == DCACHE);
    assign gnt_d  = d_req && !gnt_i;
    // req_q.write can only be set by a dcache write-back, so it marks the refill window
    assign refill = REFILL_LOCK && req_q.write && d_read;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_ld       = 1'b0;
        req_d        = '0;
        case (state_q)
            IDLE: if (gnt_i || gnt_d) begin
                req_ld       = 1'b1;
                req_d.addr   = REQ_ADDR_W'(gnt_i ? i_addr : d_addr);
                req_d.read   = gnt_i || !d_write;
                req_d.write  = gnt_d && d_write;
                req_d.wdata  = (gnt_d && d_write) ? REQ_LINE_W'(d_wdata) : '0;
                last_grant_d = gnt_i ? ICACHE : DCACHE;
                state_d      = gnt_i ? I_BUSY : D_BUSY;
            end
            I_BUSY, D_BUSY: state_d = mem_resp ? DONE : state_q;
            DONE: begin
                req_ld     = refill;
                req_d.addr = REQ_ADDR_W'(d_addr);
                req_d.read = 1'b1;
                state_d    = refill ? D_BUSY : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= DCACHE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy      = state_q == I_BUSY || state_q == D_BUSY;
    assign mem_addr  = busy ? ADDR_W'(req_q.addr) : '0;
    assign mem_read  = busy && req_q.read;
    assign mem_write = busy && req_q.write;
    assign mem_wdata = busy ? LINE_W'(req_q.wdata) : '0;
    // a response landing on the reset cycle belongs to an abandoned request
    assign i_resp    = !rst && state_q == I_BUSY && mem_resp;
    assign d_resp    = !rst && state_q == D_BUSY && mem_resp;
    assign i_rdata   = i_resp ? mem_rdata : '0;
    assign d_rdata   = d_resp ? mem_rdata : '0;
    assign spurious  = mem_resp && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst) assert (!spurious) else $warning("spurious mem_resp ignored");
    end
endmodule
